// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters,
// same-cycle next-PC prediction for IF and misprediction detection for EX.
module branch_predictor #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic [31:0]       pc_if,
  output logic              pred_taken,
  output logic [31:0]       pred_pc,
  input  logic              ex_valid,
  input  logic [31:0]       pc_ex,
  input  logic              actual_taken,
  input  logic [31:0]       actual_target,
  input  logic [31:0]       ex_pred_pc,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int unsigned TAG_W = 32 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] idx_if;
  logic [IDX_W-1:0] idx_ex;
  logic             hit_if;
  logic             hit_ex;
  logic [31:0]      actual_next;
  logic             upd;

  assign idx_if = pc_if[IDX_W-1:0];
  assign idx_ex = pc_ex[IDX_W-1:0];
  assign upd    = ex_valid & ~halt;

  // IF-stage lookup; reads the registered table, so a same-cycle write is not seen
  always_comb begin
    hit_if     = valid_q[idx_if] && (tag_q[idx_if] == pc_if[31:IDX_W]);
    pred_taken = hit_if & ctr_q[idx_if][1];
    pred_pc    = pred_taken ? target_q[idx_if] : pc_if + 32'd1;
  end

  // EX-stage resolution: one compare covers wrong direction and wrong target
  always_comb begin
    hit_ex      = valid_q[idx_ex] && (tag_q[idx_ex] == pc_ex[31:IDX_W]);
    actual_next = actual_taken ? actual_target : pc_ex + 32'd1;
    redirect_pc = actual_next;
    flush       = upd & (actual_next != ex_pred_pc);
  end

  // Table training on resolved control transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
    end else if (upd) begin
      if (hit_ex) begin
        if (actual_taken) begin
          if (ctr_q[idx_ex] != 2'b11) ctr_q[idx_ex] <= ctr_q[idx_ex] + 2'd1;
          target_q[idx_ex] <= actual_target;
        end else if (ctr_q[idx_ex] != 2'b00) begin
          ctr_q[idx_ex] <= ctr_q[idx_ex] - 2'd1;
        end
      end else if (actual_taken) begin
        // Taken miss replaces whatever occupies the slot
        valid_q[idx_ex]  <= 1'b1;
        tag_q[idx_ex]    <= pc_ex[31:IDX_W];
        target_q[idx_ex] <= actual_target;
        ctr_q[idx_ex]    <= 2'b10;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (upd) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + STAT_W'(1);
      if (flush && (miss_cnt != '1)) miss_cnt <= miss_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (STAT_W=4 so saturation is reachable).
module tb_branch_predictor;

  localparam int unsigned STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              halt;
  logic [31:0]       pc_if;
  logic              pred_taken;
  logic [31:0]       pred_pc;
  logic              ex_valid;
  logic [31:0]       pc_ex;
  logic              actual_taken;
  logic [31:0]       actual_target;
  logic [31:0]       ex_pred_pc;
  logic              flush;
  logic [31:0]       redirect_pc;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.ENTRIES(8), .IDX_W(3), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .halt(halt), .pc_if(pc_if),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .ex_valid(ex_valid), .pc_ex(pc_ex), .actual_taken(actual_taken),
    .actual_target(actual_target), .ex_pred_pc(ex_pred_pc),
    .flush(flush), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                      input logic [31:0] exp_pc);
    pc_if = pc;
    #1;
    chk({tag, "_taken"}, 32'(pred_taken), 32'(exp_t));
    chk({tag, "_pc"}, pred_pc, exp_pc);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic [31:0] epc,
                         input logic exp_fl, input logic [31:0] exp_rd);
    ex_valid = 1'b1; pc_ex = pc; actual_taken = tk; actual_target = tgt; ex_pred_pc = epc;
    #1;
    chk({tag, "_flush"}, 32'(flush), 32'(exp_fl));
    chk({tag, "_redir"}, redirect_pc, exp_rd);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic counts(input string tag, input int b, input int m);
    chk({tag, "_bcnt"}, 32'(branch_cnt), 32'(b));
    chk({tag, "_mcnt"}, 32'(miss_cnt), 32'(m));
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; pc_if = 32'h10; ex_valid = 1'b0;
    pc_ex = '0; actual_taken = 1'b0; actual_target = '0; ex_pred_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    look("rst", 32'h10, 1'b0, 32'h11);
    counts("rst", 0, 0);
    chk("rst_flush", 32'(flush), 32'd0);
    for (int i = 0; i < 8; i++) look("rst_idx", 32'(i), 1'b0, 32'(i + 1));
    rst = 1'b0;
    @(posedge clk); #1;

    // cold taken branch; same-cycle lookup still misses
    pc_if = 32'h10;
    ex_valid = 1'b1; pc_ex = 32'h10; actual_taken = 1'b1;
    actual_target = 32'h40; ex_pred_pc = 32'h11;
    #1;
    chk("cold_flush", 32'(flush), 32'd1);
    chk("cold_redir", redirect_pc, 32'h40);
    chk("cold_same_cyc", pred_pc, 32'h11);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    look("cold_next", 32'h10, 1'b1, 32'h40);
    counts("cold", 1, 1);

    // hysteresis: 10 -> 01 -> 10 -> 11 -> 10
    resolve("hy1", 32'h10, 1'b0, 32'h40, 32'h40, 1'b1, 32'h11);
    look("hy1", 32'h10, 1'b0, 32'h11);
    resolve("hy2", 32'h10, 1'b1, 32'h40, 32'h11, 1'b1, 32'h40);
    look("hy2", 32'h10, 1'b1, 32'h40);
    resolve("hy3", 32'h10, 1'b1, 32'h40, 32'h40, 1'b0, 32'h40);
    resolve("hy4", 32'h10, 1'b0, 32'h40, 32'h40, 1'b1, 32'h11);
    look("hy4", 32'h10, 1'b1, 32'h40);
    counts("hy", 5, 4);

    // jr target change at 0x21
    resolve("jr_alloc", 32'h21, 1'b1, 32'h80, 32'h22, 1'b1, 32'h80);
    look("jr_alloc", 32'h21, 1'b1, 32'h80);
    resolve("jr_chg", 32'h21, 1'b1, 32'h90, 32'h80, 1'b1, 32'h90);
    look("jr_chg", 32'h21, 1'b1, 32'h90);
    counts("jr", 7, 6);

    // aliasing: 0x18 evicts 0x10 (both index 0)
    resolve("alias", 32'h18, 1'b1, 32'h60, 32'h19, 1'b1, 32'h60);
    look("alias_old", 32'h10, 1'b0, 32'h11);
    look("alias_new", 32'h18, 1'b1, 32'h60);
    look("alias_other", 32'h21, 1'b1, 32'h90);

    // halt blocks flush, table and stats; lookup stays live
    halt = 1'b1;
    pc_if = 32'h18;
    resolve("halt", 32'h21, 1'b1, 32'hAA, 32'h90, 1'b0, 32'hAA);
    look("halt_live", 32'h18, 1'b1, 32'h60);
    halt = 1'b0;
    look("halt_tbl", 32'h21, 1'b1, 32'h90);
    counts("halt", 8, 7);

    // not-taken miss: correct fall-through, no allocation
    resolve("ntmiss", 32'h33, 1'b0, 32'h99, 32'h34, 1'b0, 32'h34);
    look("ntmiss", 32'h33, 1'b0, 32'h34);
    counts("ntmiss", 9, 7);

    // PC wrap
    look("wrap", 32'hFFFF_FFFF, 1'b0, 32'h0);

    // asynchronous reset mid-operation clears table and stats
    #2 rst = 1'b1;
    #1;
    look("rst2", 32'h18, 1'b0, 32'h19);
    counts("rst2", 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // saturation with 20 mispredictions
    for (int i = 0; i < 20; i++) begin
      resolve("sat", 32'h50, 1'b0, 32'h0, 32'h0, 1'b1, 32'h51);
      counts("sat", (i + 1 > 15) ? 15 : i + 1, (i + 1 > 15) ? 15 : i + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
